// File: rtl/moving_average_pkg.sv
// Shared constants and helpers for the moving-average block: window length,
// accumulator width and the sign extension used to feed the running sum.
package moving_average_pkg;

    localparam int DEF_N         = 16;
    localparam int DEF_LOG2_TAPS = 3;
    localparam int TAPS          = 1 << DEF_LOG2_TAPS;
    localparam int SUM_W         = DEF_N + DEF_LOG2_TAPS;

    function automatic int taps_of(input int log2_taps);
        return 1 << log2_taps;
    endfunction

    // Widening by LOG2_TAPS bits holds TAPS full-scale samples of either sign.
    function automatic int sum_w_of(input int n, input int log2_taps);
        return n + log2_taps;
    endfunction

    function automatic logic signed [SUM_W-1:0] sext_to_sum(input logic signed [DEF_N-1:0] x);
        return SUM_W'(x);
    endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// TAPS x N circular sample store. The entry at the write pointer is the oldest
// sample and is presented combinationally, so it is read before being overwritten.
module sample_ring_buffer
    import moving_average_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int LOG2_TAPS = DEF_LOG2_TAPS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_wr_en,
    input  logic signed [N-1:0] i_din,
    output logic signed [N-1:0] o_oldest
);

    localparam int L_TAPS = taps_of(LOG2_TAPS);

    logic signed [N-1:0]    r_mem [L_TAPS];
    logic [LOG2_TAPS-1:0]   r_wr_ptr;

    // Zeroed entries let missing taps contribute nothing during the fill phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L_TAPS; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + LOG2_TAPS'(1);
        end
    end

    assign o_oldest = r_mem[r_wr_ptr];

endmodule

// File: rtl/moving_average_accum.sv
// 2^LOG2_TAPS-point moving average using a running sum over a circular buffer,
// with a registered floor-divided output, a one-cycle valid pulse and a sticky full flag.
module moving_average_accum
    import moving_average_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int LOG2_TAPS = DEF_LOG2_TAPS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [N-1:0] sig_in,
    output logic                out_valid,
    output logic signed [N-1:0] avg_out,
    output logic                window_full
);

    localparam int L_TAPS  = taps_of(LOG2_TAPS);
    localparam int L_SUM_W = sum_w_of(N, LOG2_TAPS);
    localparam int CNT_W   = LOG2_TAPS + 2;
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(L_TAPS);

    function automatic logic signed [L_SUM_W-1:0] to_sum(input logic signed [N-1:0] x);
        return L_SUM_W'(x);
    endfunction

    // Arithmetic shift floors toward minus infinity; the quotient always fits N bits.
    function automatic logic signed [N-1:0] floor_avg(input logic signed [L_SUM_W-1:0] s);
        return N'(s >>> LOG2_TAPS);
    endfunction

    logic signed [N-1:0]       w_oldest;
    logic signed [L_SUM_W-1:0] w_sum_next;

    logic signed [L_SUM_W-1:0] r_sum;
    logic [CNT_W-1:0]          r_fill;
    logic signed [N-1:0]       r_avg_p1;
    logic                      r_vld_p1;
    logic                      r_full;

    sample_ring_buffer #(
        .N         (N),
        .LOG2_TAPS (LOG2_TAPS)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .i_wr_en  (in_valid),
        .i_din    (sig_in),
        .o_oldest (w_oldest)
    );

    assign w_sum_next = r_sum + to_sum(sig_in) - to_sum(w_oldest);

    // Stage p1: accumulator update and registered outputs, one clock after accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum    <= '0;
            r_fill   <= '0;
            r_avg_p1 <= '0;
            r_vld_p1 <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_sum    <= w_sum_next;
                r_avg_p1 <= floor_avg(w_sum_next);
                if (r_fill != FILL_MAX) begin
                    r_fill <= r_fill + CNT_W'(1);
                end
                if (r_fill == FILL_MAX - CNT_W'(1)) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

    assign out_valid   = r_vld_p1;
    assign avg_out     = r_avg_p1;
    assign window_full = r_full;

endmodule

// File: tb/tb_moving_average_accum.sv
// Randomised and directed bench for moving_average_accum against a queue-based
// model of the last TAPS accepted samples.
module tb_moving_average_accum;

    localparam int N         = 16;
    localparam int LOG2_TAPS = 3;
    localparam int TAPS      = 1 << LOG2_TAPS;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic signed [N-1:0] sig_in = '0;
    logic                out_valid;
    logic signed [N-1:0] avg_out;
    logic                window_full;

    int n_checks = 0;
    int n_pass   = 0;

    int q[$];
    int accepts;
    int exp_avg;
    bit exp_vld;
    bit exp_full;

    moving_average_accum #(
        .N         (N),
        .LOG2_TAPS (LOG2_TAPS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .sig_in      (sig_in),
        .out_valid   (out_valid),
        .avg_out     (avg_out),
        .window_full (window_full)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(input int s, input int d);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    function automatic int window_sum();
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    // One clock: drive at negedge, update the model on the edge, outputs settle at #1.
    task automatic step(input bit r, input bit v, input int d);
        @(negedge clk);
        reset    = r;
        in_valid = v;
        if (v || r) sig_in = N'(d);
        else        sig_in = 'x;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            accepts  = 0;
            exp_avg  = 0;
            exp_vld  = 1'b0;
            exp_full = 1'b0;
        end else if (v) begin
            q.push_back(d);
            if (q.size() > TAPS) void'(q.pop_front());
            accepts++;
            exp_avg  = floor_div(window_sum(), TAPS);
            exp_vld  = 1'b1;
            exp_full = (accepts >= TAPS);
        end else begin
            exp_vld = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1234);
            n_checks++;
            if (avg_out !== '0 || out_valid !== 1'b0 || window_full !== 1'b0)
                $display("FAIL reset cyc%0d: avg=%0d vld=%b full=%b, want 0/0/0", i, avg_out, out_valid, window_full);
            else n_pass++;
        end
        step(1'b0, 1'b1, 1234);
        n_checks++;
        if (avg_out !== N'(154) || out_valid !== 1'b1 || window_full !== 1'b0)
            $display("FAIL reset_first: avg=%0d vld=%b full=%b, want 154/1/0", avg_out, out_valid, window_full);
        else n_pass++;
    endtask

    task automatic test_step_fill();
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < TAPS; i++) begin
            step(1'b0, 1'b1, 800);
            n_checks++;
            if (avg_out !== N'(100 * (i + 1)) || out_valid !== 1'b1 || window_full !== (i == TAPS - 1))
                $display("FAIL step_fill[%0d]: avg=%0d vld=%b full=%b, want %0d/1/%0d",
                         i, avg_out, out_valid, window_full, 100 * (i + 1), i == TAPS - 1);
            else n_pass++;
        end
    endtask

    task automatic test_steady_decay();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 800);
            n_checks++;
            if (avg_out !== N'(800) || out_valid !== 1'b1 || window_full !== 1'b1)
                $display("FAIL steady[%0d]: avg=%0d vld=%b full=%b, want 800/1/1", i, avg_out, out_valid, window_full);
            else n_pass++;
        end
        for (int i = 0; i < TAPS; i++) begin
            step(1'b0, 1'b1, 0);
            n_checks++;
            if (avg_out !== N'(700 - 100 * i) || out_valid !== 1'b1 || window_full !== 1'b1)
                $display("FAIL decay[%0d]: avg=%0d vld=%b, want %0d/1", i, avg_out, out_valid, 700 - 100 * i);
            else n_pass++;
        end
    endtask

    task automatic test_signed_round();
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, -1);
        n_checks++;
        if (avg_out !== -16'sd1 || out_valid !== 1'b1)
            $display("FAIL round_neg1: avg=%0d vld=%b, want -1/1", avg_out, out_valid);
        else n_pass++;
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < TAPS; i++) begin
            step(1'b0, 1'b1, -8);
            n_checks++;
            if (avg_out !== N'(-(i + 1)))
                $display("FAIL round_neg8[%0d]: avg=%0d, want %0d", i, avg_out, -(i + 1));
            else n_pass++;
        end
    endtask

    task automatic test_extremes();
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < TAPS; i++) begin
            step(1'b0, 1'b1, 32767);
            n_checks++;
            if (avg_out !== N'(exp_avg))
                $display("FAIL ext_pos[%0d]: avg=%0d, want %0d", i, avg_out, exp_avg);
            else n_pass++;
        end
        n_checks++;
        if (avg_out !== 16'sd32767 || window_sum() != 262136)
            $display("FAIL ext_pos_final: avg=%0d, want 32767", avg_out);
        else n_pass++;
        for (int i = 0; i < TAPS; i++) begin
            step(1'b0, 1'b1, -32768);
            n_checks++;
            if (avg_out !== N'(exp_avg))
                $display("FAIL ext_neg[%0d]: avg=%0d, want %0d", i, avg_out, exp_avg);
            else n_pass++;
        end
        n_checks++;
        if (avg_out !== -16'sd32768)
            $display("FAIL ext_neg_final: avg=%0d, want -32768", avg_out);
        else n_pass++;
    endtask

    task automatic test_gaps_reset();
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 80);
            n_checks++;
            if (avg_out !== N'(10 * (i + 1)) || out_valid !== 1'b1)
                $display("FAIL gap_acc[%0d]: avg=%0d vld=%b, want %0d/1", i, avg_out, out_valid, 10 * (i + 1));
            else n_pass++;
            if (i < 4) begin
                step(1'b0, 1'b0, 0);
                n_checks++;
                if (avg_out !== N'(10 * (i + 1)) || out_valid !== 1'b0)
                    $display("FAIL gap_idle[%0d]: avg=%0d vld=%b, want %0d/0", i, avg_out, out_valid, 10 * (i + 1));
                else n_pass++;
            end
        end
        step(1'b1, 1'b1, 80);
        n_checks++;
        if (avg_out !== '0 || out_valid !== 1'b0 || window_full !== 1'b0)
            $display("FAIL mid_reset: avg=%0d vld=%b full=%b, want 0/0/0", avg_out, out_valid, window_full);
        else n_pass++;
        step(1'b0, 1'b1, 80);
        n_checks++;
        if (avg_out !== N'(10) || out_valid !== 1'b1 || window_full !== 1'b0)
            $display("FAIL after_reset: avg=%0d vld=%b full=%b, want 10/1/0", avg_out, out_valid, window_full);
        else n_pass++;
    endtask

    task automatic test_random();
        bit r, v;
        int d;
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = $urandom_range(0, 65535) - 32768;
            step(r, v, d);
            n_checks++;
            if (avg_out !== N'(exp_avg) || out_valid !== exp_vld || window_full !== exp_full)
                $display("FAIL random[%0d]: avg=%0d vld=%b full=%b, want %0d/%b/%b",
                         i, avg_out, out_valid, window_full, exp_avg, exp_vld, exp_full);
            else n_pass++;
        end
    endtask

    initial begin
        accepts  = 0;
        exp_avg  = 0;
        exp_vld  = 1'b0;
        exp_full = 1'b0;
        test_reset();
        test_step_fill();
        test_steady_decay();
        test_signed_round();
        test_extremes();
        test_gaps_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/moving_average_accum.md
Name: moving_average_accum

Overview:
- Downstream consumer of the filter's registered sample delay stage: takes the delayed sample stream and produces a 2^LOG2_TAPS-point moving average.
- Uses a running-sum architecture with a circular sample buffer and a valid-qualified input.
- Output is a registered average plus a window-full flag, feeding the filter output register / downstream logic.

Parameters:
- N, 16, sample width in bits; input and output are signed two's complement.
- LOG2_TAPS, 3, log2 of window length; TAPS = 2^LOG2_TAPS. Legal range 1..6.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  sig_in carries a new sample this cycle.
- sig_in  input  N  signed input sample from the delay stage.
- out_valid  output  1  one-cycle pulse; avg_out updated this cycle.
- avg_out  output  N  signed moving average, registered.
- window_full  output  1  high once TAPS samples have been accepted since reset; sticky.

Behaviour:
- One clock and one synchronous active-high reset: all state changes on rising clk; reset is sampled only at clk edges.
- Reset has priority over in_valid. It clears:
  - every buffer entry to 0;
  - wr_ptr to 0, fill count to 0, sum to 0;
  - avg_out = 0, out_valid = 0, window_full = 0.
- Storage: TAPS x N circular buffer; wr_ptr is LOG2_TAPS bits and wraps from TAPS-1 to 0 naturally.
- Accumulator sum: signed, width SUM_W = N + LOG2_TAPS, so it cannot overflow for any input sequence.
- Accept cycle (in_valid = 1, reset = 0):
  - oldest = buf[wr_ptr], read before the write in the same cycle;
  - buf[wr_ptr] <= sig_in;
  - sum <= sum + sext(sig_in) - sext(oldest);
  - wr_ptr <= wr_ptr + 1;
  - avg_out <= (sum + sext(sig_in) - sext(oldest)) >>> LOG2_TAPS, an arithmetic shift that floors toward minus infinity. Bits [N-1:0] of the shifted result are exact, with no saturation needed;
  - out_valid <= 1.
- Latency: one clock from accept edge to out_valid/avg_out. Throughput: one sample per clock, sustained.
- Idle cycle (in_valid = 0): buffer, sum and avg_out hold; out_valid <= 0.
- Fill phase:
  - before TAPS accepts, missing taps contribute 0 (buffer zeroed at reset), so outputs ramp;
  - 2-bit-wider fill counter saturates at TAPS;
  - window_full <= 1 on the same edge as the TAPS-th accept, so it is visible with that sample's out_valid;
  - window_full stays 1 until reset.
- Wrap-around: after the first TAPS accepts, each accept replaces exactly the oldest sample; sum always equals the sum of the last TAPS accepted samples.
- Reset mid-stream: state clears on that edge regardless of in_valid; the next accept starts a fresh fill from wr_ptr = 0.
- in_valid held high during reset: the sample is discarded.
- Do not rely on sig_in when in_valid = 0; X on sig_in while in_valid = 0 must not propagate.

Decomposition:
- Shared package (moving_average_pkg) holds the derived constants TAPS = 1 << LOG2_TAPS and SUM_W = N + LOG2_TAPS, plus a function sext_to_sum for sign extension.
- One natural sub-module: sample_ring_buffer, holding the TAPS x N register array, wr_ptr and read-before-write of the oldest entry, with synchronous clear.
- The top level holds the accumulator, fill counter and output registers.

Test Plan:
1. Reset: reset = 1 for 3 clocks with in_valid = 1, sig_in = 1234 -> avg_out = 0, out_valid = 0, window_full = 0; first sample after release starts the fill.
2. Step fill (N=16, LOG2_TAPS=3): 8 consecutive accepts of 800 -> avg_out = 100, 200, ..., 800 on successive cycles, each with out_valid = 1; window_full rises with the 8th output.
3. Steady state and decay: after test 2, 4 more accepts of 800 -> 800 each; then 8 accepts of 0 -> 700, 600, ..., 0.
4. Signed rounding:
   - after reset, one accept of -1 -> avg_out = -1 (floor of -1/8);
   - after reset, 8 accepts of -8 -> -1, -2, ..., -8.
5. Extremes:
   - 8 accepts of 32767 -> final avg_out = 32767, sum = 262136;
   - then 8 accepts of -32768 -> final avg_out = -32768, no wrap at any step.
6. Gaps and reset mid-stream:
   - accepts of 80 with in_valid low between them -> out_valid pulses only after accepts, and avg_out holds during gaps;
   - reset asserted after the 5th accept while in_valid = 1 -> outputs cleared;
   - next accept of 80 -> avg_out = 10, window_full = 0.
